// File: rtl/gsram_bist.sv
// gsram_bist - March C- self-test initiator for port 0 of a generic SRAM macro.
//
// Runs the six March C- elements over all 2^ABITS words, compares every read
// one cycle after it is issued (synchronous-read macro), and reports the
// result. All SRAM-side outputs are registered.
//
// Ports:
//   CLK, RSTN     clock (rising edge), asynchronous active-low reset
//   start         begin a test; honoured only while idle
//   busy          test in progress
//   done          test finished; held until the next accepted start
//   fail          at least one miscompare; held with done
//   fail_addr     address of the first miscompare
//   fail_cnt      miscompare count, saturating at all-ones
//   sram_a/d      SRAM address / write data
//   sram_we/ce    SRAM write enable / chip enable (active high)
//   sram_q        SRAM read data, valid the cycle after a read access
module gsram_bist #(
    parameter int unsigned ABITS = 9,
    parameter int unsigned DBITS = 32,
    parameter int unsigned CBITS = 16
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             fail,
    output logic [ABITS-1:0] fail_addr,
    output logic [CBITS-1:0] fail_cnt,
    output logic [ABITS-1:0] sram_a,
    output logic [DBITS-1:0] sram_d,
    output logic             sram_we,
    output logic             sram_ce,
    input  logic [DBITS-1:0] sram_q
);

    typedef enum logic [2:0] {
        S_IDLE, S_M0, S_M1, S_M2, S_M3, S_M4, S_M5, S_DRAIN
    } state_t;

    localparam logic [ABITS-1:0] ALAST = '1;

    state_t           state, nstate;
    logic [ABITS-1:0] addr, naddr;
    logic             ph, nph;       // two-op elements: 0 = read, 1 = write

    logic             op_act, op_wr, op_one;
    logic             rd_one;        // expected pattern of the read now on the bus
    logic             chk_v, chk_one;
    logic [ABITS-1:0] chk_a;

    // Next operation (state, address, phase)
    always_comb begin
        nstate = state;
        naddr  = addr;
        nph    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    nstate = S_M0;
                    naddr  = '0;
                end
            end
            S_M0: begin
                if (addr == ALAST) begin
                    nstate = S_M1;
                    naddr  = '0;
                end else begin
                    naddr = addr + ABITS'(1);
                end
            end
            S_M1, S_M2: begin
                if (!ph) begin
                    nph = 1'b1;
                end else if (addr == ALAST) begin
                    if (state == S_M1) begin
                        nstate = S_M2;
                        naddr  = '0;
                    end else begin
                        nstate = S_M3;
                        naddr  = ALAST;
                    end
                end else begin
                    naddr = addr + ABITS'(1);
                end
            end
            S_M3, S_M4: begin
                if (!ph) begin
                    nph = 1'b1;
                end else if (addr == '0) begin
                    if (state == S_M3) begin
                        nstate = S_M4;
                        naddr  = ALAST;
                    end else begin
                        nstate = S_M5;
                        naddr  = '0;
                    end
                end else begin
                    naddr = addr - ABITS'(1);
                end
            end
            S_M5: begin
                if (addr == ALAST) begin
                    nstate = S_DRAIN;
                    naddr  = '0;
                end else begin
                    naddr = addr + ABITS'(1);
                end
            end
            S_DRAIN: nstate = S_IDLE;
            default: nstate = S_IDLE;
        endcase
    end

    // Decode of the next operation; op_one is the write data for writes and
    // the expected read value for reads.
    always_comb begin
        op_act = 1'b0;
        op_wr  = 1'b0;
        op_one = 1'b0;
        unique case (nstate)
            S_M0: begin
                op_act = 1'b1;
                op_wr  = 1'b1;
            end
            S_M1, S_M3: begin
                op_act = 1'b1;
                op_wr  = nph;
                op_one = nph;
            end
            S_M2, S_M4: begin
                op_act = 1'b1;
                op_wr  = nph;
                op_one = ~nph;
            end
            S_M5: op_act = 1'b1;
            default: op_act = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state     <= S_IDLE;
            addr      <= '0;
            ph        <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_cnt  <= '0;
            sram_a    <= '0;
            sram_d    <= '0;
            sram_we   <= 1'b0;
            sram_ce   <= 1'b0;
            rd_one    <= 1'b0;
            chk_v     <= 1'b0;
            chk_one   <= 1'b0;
            chk_a     <= '0;
        end else begin
            state   <= nstate;
            addr    <= naddr;
            ph      <= nph;
            busy    <= (nstate != S_IDLE);
            sram_ce <= op_act;
            sram_we <= op_act & op_wr;
            sram_a  <= op_act ? naddr : '0;
            sram_d  <= (op_act & op_wr & op_one) ? '1 : '0;
            rd_one  <= op_one;

            // The read on the bus this cycle returns data next cycle; keep
            // its expectation one stage behind the bus.
            chk_v   <= sram_ce & ~sram_we;
            chk_one <= rd_one;
            chk_a   <= sram_a;

            if (state == S_IDLE && start) begin
                done      <= 1'b0;
                fail      <= 1'b0;
                fail_cnt  <= '0;
                fail_addr <= '0;
            end else begin
                if (chk_v && (sram_q != (chk_one ? {DBITS{1'b1}} : {DBITS{1'b0}}))) begin
                    if (fail_cnt != '1)
                        fail_cnt <= fail_cnt + CBITS'(1);
                    if (!fail) begin
                        fail      <= 1'b1;
                        fail_addr <= chk_a;
                    end
                end
                if (state == S_DRAIN)
                    done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gsram_bist.sv
// tb_gsram_bist - directed bench for gsram_bist: three instances with
// behavioural read-before-write SRAM models (clean / stuck-at / coupling /
// stuck-at-zero variants).
module tb_gsram_bist;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;
    logic RSTN;

    // ABITS=9 instance
    logic        start9, busy9, done9, fail9, we9, ce9;
    logic [8:0]  fa9, a9;
    logic [15:0] cnt9;
    logic [31:0] d9, q9;
    logic [31:0] mem9 [512];
    int          mode9;

    // ABITS=2 instance
    logic        start2, busy2, done2, fail2, we2, ce2;
    logic [1:0]  fa2, a2;
    logic [15:0] cnt2;
    logic [31:0] d2, q2;
    logic [31:0] mem2 [4];
    int          mode2;

    // ABITS=2, CBITS=2 instance, all-zero-stuck memory
    logic        starts, busys, dones, fails, wes, ces;
    logic [1:0]  fas, as_, cnts;
    logic [31:0] ds, qs;

    gsram_bist #(.ABITS(9), .DBITS(32), .CBITS(16)) u9 (
        .CLK(CLK), .RSTN(RSTN), .start(start9), .busy(busy9), .done(done9),
        .fail(fail9), .fail_addr(fa9), .fail_cnt(cnt9), .sram_a(a9),
        .sram_d(d9), .sram_we(we9), .sram_ce(ce9), .sram_q(q9));

    gsram_bist #(.ABITS(2), .DBITS(32), .CBITS(16)) u2 (
        .CLK(CLK), .RSTN(RSTN), .start(start2), .busy(busy2), .done(done2),
        .fail(fail2), .fail_addr(fa2), .fail_cnt(cnt2), .sram_a(a2),
        .sram_d(d2), .sram_we(we2), .sram_ce(ce2), .sram_q(q2));

    gsram_bist #(.ABITS(2), .DBITS(32), .CBITS(2)) us (
        .CLK(CLK), .RSTN(RSTN), .start(starts), .busy(busys), .done(dones),
        .fail(fails), .fail_addr(fas), .fail_cnt(cnts), .sram_a(as_),
        .sram_d(ds), .sram_we(wes), .sram_ce(ces), .sram_q(qs));

    // mode9=1: bit 3 of word 0x1A5 reads as 1
    always @(posedge CLK) begin
        if (ce9) begin
            if (we9) mem9[a9] <= d9;
            else     q9 <= (mode9 == 1 && a9 == 9'h1A5) ? (mem9[a9] | 32'h8) : mem9[a9];
        end
    end

    // mode2=1: writing all-ones to word 2 forces word 1 to all-ones
    always @(posedge CLK) begin
        if (ce2) begin
            if (we2) begin
                mem2[a2] <= d2;
                if (mode2 == 1 && a2 == 2'd2 && d2 == 32'hFFFF_FFFF)
                    mem2[1] <= 32'hFFFF_FFFF;
            end else begin
                q2 <= mem2[a2];
            end
        end
    end

    always @(posedge CLK) begin
        if (ces && !wes) qs <= 32'h0;
    end

    int total = 0;
    int bad   = 0;
    int bcyc, nacc, terr;
    logic        lwe [64];
    logic [1:0]  la  [64];
    logic [31:0] ld  [64];
    logic        ewe [40];
    logic [1:0]  ea  [40];
    logic [31:0] ed  [40];
    int          ne;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic w, input int a, input logic [31:0] d);
        ewe[ne] = w;
        ea[ne]  = 2'(a);
        ed[ne]  = d;
        ne++;
    endtask

    task automatic run9();
        int j;
        bcyc = 0; nacc = 0; terr = 0;
        @(negedge CLK); start9 = 1'b1;
        @(negedge CLK); start9 = 1'b0;
        while (busy9 && bcyc < 20000) begin
            bcyc++;
            if (ce9) begin
                if (nacc < 512) begin
                    if (!(we9 === 1'b1 && d9 === 32'h0 && a9 === 9'(nacc))) terr++;
                end else if (nacc < 1536) begin
                    j = nacc - 512;
                    if (!(we9 === 1'(j % 2) && a9 === 9'(j / 2) &&
                          d9 === ((j % 2) == 1 ? 32'hFFFF_FFFF : 32'h0))) terr++;
                end
                nacc++;
            end
            @(negedge CLK);
        end
    endtask

    task automatic run2(input bit pulse);
        bcyc = 0; nacc = 0;
        @(negedge CLK); start2 = 1'b1;
        @(negedge CLK); start2 = 1'b0;
        while (busy2 && bcyc < 2000) begin
            bcyc++;
            start2 = pulse && (bcyc == 5 || bcyc == 17 || bcyc == 30);
            if (ce2) begin
                if (nacc < 64) begin
                    lwe[nacc] = we2; la[nacc] = a2; ld[nacc] = d2;
                end
                nacc++;
            end
            @(negedge CLK);
        end
        start2 = 1'b0;
    endtask

    task automatic runs();
        bcyc = 0;
        @(negedge CLK); starts = 1'b1;
        @(negedge CLK); starts = 1'b0;
        while (busys && bcyc < 2000) begin
            bcyc++;
            @(negedge CLK);
        end
    endtask

    initial begin
        RSTN = 1'b1; start9 = 1'b0; start2 = 1'b0; starts = 1'b0;
        mode9 = 0; mode2 = 0;

        // expected N=4 March C- op sequence (we, addr, data)
        ne = 0;
        for (int a = 0; a < 4; a++) push(1'b1, a, 32'h0);
        for (int a = 0; a < 4; a++) begin push(1'b0, a, 32'h0); push(1'b1, a, 32'hFFFF_FFFF); end
        for (int a = 0; a < 4; a++) begin push(1'b0, a, 32'h0); push(1'b1, a, 32'h0); end
        for (int a = 3; a >= 0; a--) begin push(1'b0, a, 32'h0); push(1'b1, a, 32'hFFFF_FFFF); end
        for (int a = 3; a >= 0; a--) begin push(1'b0, a, 32'h0); push(1'b1, a, 32'h0); end
        for (int a = 0; a < 4; a++) push(1'b0, a, 32'h0);

        // reset values
        #2 RSTN = 1'b0;
        #10;
        chk("rst_busy", 64'(busy9), 64'd0);
        chk("rst_done", 64'(done9), 64'd0);
        chk("rst_fail", 64'(fail9), 64'd0);
        chk("rst_faddr", 64'(fa9), 64'd0);
        chk("rst_fcnt", 64'(cnt9), 64'd0);
        chk("rst_a", 64'(a9), 64'd0);
        chk("rst_d", 64'(d9), 64'd0);
        chk("rst_we", 64'(we9), 64'd0);
        chk("rst_ce", 64'(ce9), 64'd0);
        @(negedge CLK); RSTN = 1'b1;
        repeat (2) @(negedge CLK);

        // clean N=512 run
        run9();
        chk("clean_busy_cyc", 64'(bcyc), 64'd5121);
        chk("clean_accesses", 64'(nacc), 64'd5120);
        chk("clean_traffic_err", 64'(terr), 64'd0);
        chk("clean_busy", 64'(busy9), 64'd0);
        chk("clean_done", 64'(done9), 64'd1);
        chk("clean_fail", 64'(fail9), 64'd0);
        chk("clean_fcnt", 64'(cnt9), 64'd0);

        // stuck-at-1, bit 3 of 0x1A5 (restart with done=1)
        mode9 = 1;
        run9();
        chk("sa1_done", 64'(done9), 64'd1);
        chk("sa1_fail", 64'(fail9), 64'd1);
        chk("sa1_faddr", 64'(fa9), 64'h1A5);
        chk("sa1_fcnt", 64'(cnt9), 64'd3);

        // op order on N=4, with stray start pulses while busy
        run2(1'b1);
        chk("ord_busy_cyc", 64'(bcyc), 64'd41);
        chk("ord_accesses", 64'(nacc), 64'd40);
        for (int i = 0; i < 40; i++)
            chk($sformatf("ord_op%0d", i), {29'd0, lwe[i], la[i], ld[i]}, {29'd0, ewe[i], ea[i], ed[i]});
        chk("ord_done", 64'(done2), 64'd1);
        chk("ord_fail", 64'(fail2), 64'd0);

        // coupling fault: w1 @2 forces @1 to 1; only M3 r0 @1 sees it
        mode2 = 1;
        run2(1'b0);
        chk("cpl_done", 64'(done2), 64'd1);
        chk("cpl_fail", 64'(fail2), 64'd1);
        chk("cpl_faddr", 64'(fa2), 64'd1);
        chk("cpl_fcnt", 64'(cnt2), 64'd1);

        // saturation: 8 failing r1 reads, 2-bit counter
        runs();
        chk("sat_done", 64'(dones), 64'd1);
        chk("sat_fail", 64'(fails), 64'd1);
        chk("sat_faddr", 64'(fas), 64'd0);
        chk("sat_fcnt", 64'(cnts), 64'd3);

        // start clears previous result; reset during M3 aborts
        @(negedge CLK); start9 = 1'b1;
        @(negedge CLK); start9 = 1'b0;
        repeat (9) @(negedge CLK);
        chk("restart_done", 64'(done9), 64'd0);
        chk("restart_fail", 64'(fail9), 64'd0);
        chk("restart_fcnt", 64'(cnt9), 64'd0);
        chk("restart_faddr", 64'(fa9), 64'd0);
        repeat (2700) @(negedge CLK);
        chk("m3_busy", 64'(busy9), 64'd1);
        chk("m3_fail", 64'(fail9), 64'd1);
        #2 RSTN = 1'b0;
        #1;
        chk("abort_busy", 64'(busy9), 64'd0);
        chk("abort_fail", 64'(fail9), 64'd0);
        chk("abort_fcnt", 64'(cnt9), 64'd0);
        chk("abort_faddr", 64'(fa9), 64'd0);
        chk("abort_ce", 64'(ce9), 64'd0);
        chk("abort_we", 64'(we9), 64'd0);
        chk("abort_a", 64'(a9), 64'd0);
        chk("abort_d", 64'(d9), 64'd0);
        chk("abort_done", 64'(done9), 64'd0);
        repeat (3) @(negedge CLK);
        chk("rst_hold_ce", 64'(ce9), 64'd0);
        RSTN = 1'b1;
        repeat (2) @(negedge CLK);
        chk("post_rst_ce", 64'(ce9), 64'd0);
        chk("post_rst_busy", 64'(busy9), 64'd0);

        mode9 = 0;
        run9();
        chk("rerun_busy_cyc", 64'(bcyc), 64'd5121);
        chk("rerun_traffic_err", 64'(terr), 64'd0);
        chk("rerun_done", 64'(done9), 64'd1);
        chk("rerun_fail", 64'(fail9), 64'd0);
        chk("rerun_fcnt", 64'(cnt9), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
